// File: rtl/camera_alarm_scheduler.sv
// -----------------------------------------------------------------------------
// camera_alarm_scheduler
//   Sequences a 9-camera surveillance array (S0..S8, three groups of three).
//   With no motion pending, monitor power rotates through the groups
//   {S0-S2}, {S3-S5} and {S6-S8}. Each group stays on for DWELL cycles.
//   A motion event pre-empts the rotation. Cameras with pending events are
//   then granted one at a time, in round-robin order, for ALARM_HOLD cycles
//   each. After that the rotation resumes in the group where it was frozen.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   motion       in   9      per-camera motion event (bit i = camera Si)
//   cam_on       out  9      camera enables (bit i drives Si)
//   group        out  2      current rotation group 0..2 (held during alarm)
//   alarm        out  1      high while in the ALARM state
//   alarm_cam    out  4      index of the granted camera, 0 when not in alarm
//   alarm_count  out  CNT_W  grants since reset, saturating at all-ones
//
// Every output is driven from registered state only.
// -----------------------------------------------------------------------------
module camera_alarm_scheduler #(
  parameter int DWELL      = 4,
  parameter int ALARM_HOLD = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       motion,
  output logic [8:0]       cam_on,
  output logic [1:0]       group,
  output logic             alarm,
  output logic [3:0]       alarm_cam,
  output logic [CNT_W-1:0] alarm_count
);

  typedef enum logic {
    ST_ROTATE = 1'b0,
    ST_ALARM  = 1'b1
  } state_t;

  // One timer serves both states, so it is sized for the longer interval.
  localparam int TMAX = (DWELL > ALARM_HOLD) ? DWELL : ALARM_HOLD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]    DWELL_END = TW'(DWELL - 1);
  localparam logic [TW-1:0]    HOLD_END  = TW'(ALARM_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Registered state
  state_t           r_state;
  logic [1:0]       r_group;
  logic [TW-1:0]    r_timer;
  logic [8:0]       r_pending;
  logic [3:0]       r_rr_ptr;
  logic [3:0]       r_alarm_cam;
  logic [CNT_W-1:0] r_alarm_count;
  logic [8:0]       r_cam_on;

  // Next-state values
  state_t           w_state;
  logic [1:0]       w_group;
  logic [TW-1:0]    w_timer;
  logic [8:0]       w_pending;
  logic [3:0]       w_rr_ptr;
  logic [3:0]       w_alarm_cam;
  logic [CNT_W-1:0] w_alarm_count;
  logic [8:0]       w_cam_on;
  logic [8:0]       w_clr;
  logic             w_grant;

  // Round-robin search results
  logic             w_found;
  logic [3:0]       w_pick;
  logic [4:0]       w_scan;

  // Round-robin arbiter: the first pending bit at rr_ptr, rr_ptr+1, ... mod 9
  always_comb begin
    w_found = 1'b0;
    w_pick  = 4'd0;
    w_scan  = 5'd0;
    for (int k = 0; k < 9; k++) begin
      w_scan = {1'b0, r_rr_ptr} + 5'(k);
      if (w_scan >= 5'd9) begin
        w_scan = w_scan - 5'd9;
      end else begin
        w_scan = w_scan;
      end
      if (!w_found && r_pending[w_scan[3:0]]) begin
        w_found = 1'b1;
        w_pick  = w_scan[3:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state logic, grant bookkeeping and camera-enable decode
  always_comb begin
    w_state       = r_state;
    w_group       = r_group;
    w_timer       = r_timer;
    w_rr_ptr      = r_rr_ptr;
    w_alarm_cam   = r_alarm_cam;
    w_alarm_count = r_alarm_count;
    w_clr         = 9'd0;
    w_grant       = 1'b0;
    w_cam_on      = 9'h007;

    case (r_state)
      ST_ROTATE: begin
        // Pending motion wins over the dwell-end advance, so the group freezes.
        if (w_found) begin
          w_grant = 1'b1;
          w_state = ST_ALARM;
          w_timer = {TW{1'b0}};
        end else if (r_timer == DWELL_END) begin
          w_group = (r_group == 2'd2) ? 2'd0 : (r_group + 2'd1);
          w_timer = {TW{1'b0}};
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      ST_ALARM: begin
        if (r_timer == HOLD_END) begin
          w_timer = {TW{1'b0}};
          if (w_found) begin
            w_grant = 1'b1;
          end else begin
            w_state     = ST_ROTATE;
            w_alarm_cam = 4'd0;
          end
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      default: begin
        w_state     = ST_ROTATE;
        w_group     = 2'd0;
        w_timer     = {TW{1'b0}};
        w_alarm_cam = 4'd0;
      end
    endcase

    if (w_grant) begin
      w_alarm_cam = w_pick;
      w_clr       = 9'd1 << w_pick;
      w_rr_ptr    = (w_pick == 4'd8) ? 4'd0 : (w_pick + 4'd1);
      if (r_alarm_count != CNT_MAX) begin
        w_alarm_count = r_alarm_count + CNT_W'(1);
      end else begin
        w_alarm_count = r_alarm_count;
      end
    end else begin
      w_clr = 9'd0;
    end

    // A motion bit that arrives with its own grant re-arms it as a new event.
    w_pending = (r_pending & ~w_clr) | motion;

    if (w_state == ST_ALARM) begin
      w_cam_on = 9'd1 << w_alarm_cam;
    end else begin
      case (w_group)
        2'd0:    w_cam_on = 9'h007;
        2'd1:    w_cam_on = 9'h038;
        2'd2:    w_cam_on = 9'h1C0;
        default: w_cam_on = 9'h007;
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_ROTATE;
      r_group       <= 2'd0;
      r_timer       <= {TW{1'b0}};
      r_pending     <= 9'd0;
      r_rr_ptr      <= 4'd0;
      r_alarm_cam   <= 4'd0;
      r_alarm_count <= {CNT_W{1'b0}};
      r_cam_on      <= 9'h007;
    end else begin
      r_state       <= w_state;
      r_group       <= w_group;
      r_timer       <= w_timer;
      r_pending     <= w_pending;
      r_rr_ptr      <= w_rr_ptr;
      r_alarm_cam   <= w_alarm_cam;
      r_alarm_count <= w_alarm_count;
      r_cam_on      <= w_cam_on;
    end
  end

  assign cam_on      = r_cam_on;
  assign group       = r_group;
  assign alarm       = (r_state == ST_ALARM);
  assign alarm_cam   = r_alarm_cam;
  assign alarm_count = r_alarm_count;

endmodule
